prog_loader: RTL and testbench



---
 rtl/prog_loader_pkg.sv | 31 +++
 rtl/prog_loader_buf.sv | 29 ++
 rtl/prog_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_prog_loader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared definitions for the program loader.
//   - state_t   : loader FSM states (CHK exists only with PROG_LOADER_CHECKSUM_EN)
//   - CMD_*     : frame command bytes
//   - ADDR_W    : processor memory address width (bounds BUF_DEPTH to 2048)
//   - is_seg_cmd: true for the two segment-load command bytes
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
package prog_loader_pkg;

  localparam int unsigned ADDR_W = 11;

  localparam logic [7:0] CMD_INST = 8'hA5;
  localparam logic [7:0] CMD_DATA = 8'h5A;
  localparam logic [7:0] CMD_RUN  = 8'hC3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CNT_HI  = 3'd1,
    ST_CNT_LO  = 3'd2,
    ST_PAYLOAD = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
    ST_CHK     = 3'd4,
`endif
    ST_BURST   = 3'd5,
    ST_RUN     = 3'd6
  } state_t;

  function automatic logic is_seg_cmd(input logic [7:0] b);
    return (b == CMD_INST) || (b == CMD_DATA);
  endfunction

endpackage

// File: rtl/prog_loader_buf.sv
// loader_buf: BUF_DEPTH x 32 segment buffer.
//   clk      : write clock
//   we       : write enable (synchronous)
//   wr_idx   : write word index
//   wr_data  : word to store
//   rd_idx   : read word index
//   rd_data  : buf[rd_idx], combinational so the consumer can register it
//              on the same edge that advances rd_idx
module loader_buf #(
  parameter int unsigned BUF_DEPTH = 256,
  parameter int unsigned IDX_W     = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/prog_loader.sv
// prog_loader: assembles big-endian words from a UART byte stream into a
// local buffer, then bursts them into instruction or data memory one word
// per clock while the processor is out of reset (its PC supplies the
// address). A run command releases the processor with both strobes low.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   rx_valid  : rx_data holds a new byte
//   rx_data   : received byte
//   rx_ready  : loader accepts a byte this cycle
//   proc_rst  : active-high processor reset
//   inst_load : instruction-memory write strobe
//   data_load : data-memory write strobe
//   data      : word being written
//   running   : processor released to execute
//   err       : sticky error, cleared only by rst
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (XOR checksum byte after
// the payload; mismatch discards the segment).
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        proc_rst,
  output logic        inst_load,
  output logic        data_load,
  output logic [31:0] data,
  output logic        running,
  output logic        err
);

  localparam int unsigned IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(BUF_DEPTH);

  state_t             state;
  logic               seg_data;
  logic [7:0]         cnt_hi;
  logic [CNT_W-1:0]   count;
  logic [1:0]         lane;
  logic [23:0]        shreg;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               burst_end;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]         csum;
`endif

  logic               xfer;
  logic               buf_we;
  logic [31:0]        buf_wdata;
  logic [31:0]        buf_rdata;
  logic [CNT_W-1:0]   cnt_next;
  logic               last_wr;
  logic               last_rd;

  assign xfer      = rx_valid && rx_ready;
  assign buf_we    = xfer && (state == ST_PAYLOAD) && (lane == 2'd3);
  assign buf_wdata = {shreg, rx_data};
  assign cnt_next  = CNT_W'({cnt_hi, rx_data});
  assign last_wr   = (CNT_W'(wr_idx) == (count - CNT_W'(1)));
  assign last_rd   = (CNT_W'(rd_idx) == (count - CNT_W'(1)));

  loader_buf #(
    .BUF_DEPTH (BUF_DEPTH),
    .IDX_W     (IDX_W)
  ) u_buf (
    .clk     (clk),
    .we      (buf_we),
    .wr_idx  (wr_idx),
    .wr_data (buf_wdata),
    .rd_idx  (rd_idx),
    .rd_data (buf_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      seg_data  <= 1'b0;
      cnt_hi    <= '0;
      count     <= '0;
      lane      <= '0;
      shreg     <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      burst_end <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
      rx_ready  <= 1'b1;
      proc_rst  <= 1'b1;
      inst_load <= 1'b0;
      data_load <= 1'b0;
      data      <= '0;
      running   <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            if (is_seg_cmd(rx_data)) begin
              seg_data <= (rx_data == CMD_DATA);
              state    <= ST_CNT_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
              csum     <= '0;
`endif
            end else if (rx_data == CMD_RUN) begin
              proc_rst <= 1'b0;
              running  <= 1'b1;
              state    <= ST_RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end

        ST_CNT_HI: begin
          if (xfer) begin
            cnt_hi <= rx_data;
            state  <= ST_CNT_LO;
          end
        end

        ST_CNT_LO: begin
          if (xfer) begin
            count  <= cnt_next;
            lane   <= '0;
            wr_idx <= '0;
            if (cnt_next == '0) begin
              state <= ST_IDLE;
            end else if ({1'b0, cnt_next} > DEPTH_C) begin
              // Oversized segment: reject the header only; the host resends.
              err   <= 1'b1;
              state <= ST_IDLE;
            end else begin
              state <= ST_PAYLOAD;
            end
          end
        end

        ST_PAYLOAD: begin
          if (xfer) begin
            lane  <= lane + 2'd1;
            shreg <= {shreg[15:0], rx_data};
`ifdef PROG_LOADER_CHECKSUM_EN
            csum  <= csum ^ rx_data;
`endif
            if (lane == 2'd3) begin
              if (last_wr) begin
                wr_idx <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                state  <= ST_CHK;
`else
                rx_ready <= 1'b0;
                state    <= ST_BURST;
`endif
              end else begin
                wr_idx <= wr_idx + 1'b1;
              end
            end
          end
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (xfer) begin
            if (rx_data == csum) begin
              rx_ready <= 1'b0;
              state    <= ST_BURST;
            end else begin
              err   <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
`endif

        ST_BURST: begin
          // burst_end marks the extra cycle after the last word, in which the
          // strobe drops and the processor goes back into reset.
          if (!burst_end) begin
            proc_rst  <= 1'b0;
            inst_load <= !seg_data;
            data_load <= seg_data;
            data      <= buf_rdata;
            if (last_rd) burst_end <= 1'b1;
            else         rd_idx    <= rd_idx + 1'b1;
          end else begin
            proc_rst  <= 1'b1;
            inst_load <= 1'b0;
            data_load <= 1'b0;
            data      <= '0;
            rx_ready  <= 1'b1;
            rd_idx    <= '0;
            wr_idx    <= '0;
            burst_end <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        ST_RUN: begin
          if (xfer && is_seg_cmd(rx_data)) begin
            proc_rst <= 1'b1;
            running  <= 1'b0;
            seg_data <= (rx_data == CMD_DATA);
            state    <= ST_CNT_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        proc_rst;
  logic        inst_load;
  logic        data_load;
  logic [31:0] data;
  logic        running;
  logic        err;

  always #5 clk = ~clk;

  prog_loader #(
    .BUF_DEPTH (DEPTH),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .proc_rst  (proc_rst),
    .inst_load (inst_load),
    .data_load (data_load),
    .data      (data),
    .running   (running),
    .err       (err)
  );

  // Processor side: PC cleared by proc_rst, +1 per clock, addresses memories.
  bit   [31:0]       imem [1 << ADDR_W];
  bit   [31:0]       dmem [1 << ADDR_W];
  logic [ADDR_W-1:0] pc;
  int unsigned n_inst = 0, n_data = 0, n_prst_low = 0, n_both = 0;

  always @(posedge clk) begin
    if (inst_load && data_load) n_both <= n_both + 1;
    if (inst_load) n_inst <= n_inst + 1;
    if (data_load) n_data <= n_data + 1;
    if (!proc_rst) n_prst_low <= n_prst_low + 1;
    if (proc_rst) pc <= '0;
    else begin
      if (inst_load) imem[pc] <= data;
      if (data_load) dmem[pc] <= data;
      pc <= pc + 1'b1;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_ready_timeout", {31'b0, rx_ready}, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  logic [31:0] words [$];

  task automatic send_body();
    logic [31:0] w;
    logic [7:0]  cs;
    cs = 8'h00;
    send_byte(8'(words.size() >> 8));
    send_byte(8'(words.size()));
    foreach (words[i]) begin
      w = words[i];
      for (int k = 3; k >= 0; k--) begin
        send_byte(w[k*8 +: 8]);
        cs = cs ^ w[k*8 +: 8];
      end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(cs);
`endif
  endtask

  task automatic send_seg(input logic [7:0] cmd);
    send_byte(cmd);
    send_body();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(1);
  endtask

  function automatic logic [31:0] pat(input int unsigned i);
    return {8'(i), ~8'(i), 16'hA55A};
  endfunction

  int unsigned s_inst, s_data, s_prst;

  task automatic snap();
    s_inst = n_inst;
    s_data = n_data;
    s_prst = n_prst_low;
  endtask

  initial begin
    int unsigned seen, t;
    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    check("rst_proc_rst",  {31'b0, proc_rst},  32'd1);
    check("rst_inst_load", {31'b0, inst_load}, 32'd0);
    check("rst_data_load", {31'b0, data_load}, 32'd0);
    check("rst_rx_ready",  {31'b0, rx_ready},  32'd1);
    check("rst_running",   {31'b0, running},   32'd0);
    check("rst_err",       {31'b0, err},       32'd0);
    check("rst_data",      data,               32'h0);
    rst = 1'b1;
    idle(2);

    // Instruction segment, two words
    snap();
    words = {32'h11223344, 32'h55667788};
    send_seg(CMD_INST);
    idle(6);
    check("inst_strobes",   n_inst - s_inst,     32'd2);
    check("inst_no_dload",  n_data - s_data,     32'd0);
    check("inst_prst_low",  n_prst_low - s_prst, 32'd2);
    check("inst_imem0",     imem[0],             32'h11223344);
    check("inst_imem1",     imem[1],             32'h55667788);
    check("inst_prst_back", {31'b0, proc_rst},   32'd1);
    check("inst_rx_ready",  {31'b0, rx_ready},   32'd1);

    // Data segment, then run
    snap();
    words = {32'hDEADBEEF};
    send_seg(CMD_DATA);
    idle(5);
    check("data_strobes",  n_data - s_data, 32'd1);
    check("data_no_iload", n_inst - s_inst, 32'd0);
    check("data_dmem0",    dmem[0],         32'hDEADBEEF);
    send_byte(CMD_RUN);
    check("run_running",   {31'b0, running},  32'd1);
    check("run_proc_rst",  {31'b0, proc_rst}, 32'd0);
    idle(5);
    send_byte(8'h77);
    idle(2);
    check("run_hold",      {31'b0, running},  32'd1);
    check("run_hold_prst", {31'b0, proc_rst}, 32'd0);
    check("run_junk_err",  {31'b0, err},      32'd0);

    // Segment command from RUN re-enters loading
    send_byte(CMD_INST);
    check("rerun_prst",    {31'b0, proc_rst}, 32'd1);
    check("rerun_running", {31'b0, running},  32'd0);
    words = {32'hCAFEBABE};
    send_body();
    idle(5);
    check("rerun_imem0",   imem[0], 32'hCAFEBABE);

    // Full-depth segment
    snap();
    words.delete();
    for (int unsigned i = 0; i < DEPTH; i++) words.push_back(pat(i));
    send_seg(CMD_INST);
    idle(DEPTH + 6);
    check("full_strobes", n_inst - s_inst, DEPTH);
    check("full_imem0",   imem[0],         32'h00FFA55A);
    check("full_imem128", imem[128],       32'h807FA55A);
    check("full_imem255", imem[255],       32'hFF00A55A);
    check("full_err",     {31'b0, err},    32'd0);

    // Zero count: header only, back to IDLE, not an error
    send_byte(CMD_INST); send_byte(8'h00); send_byte(8'h00);
    idle(2);
    check("cnt0_err", {31'b0, err}, 32'd0);
    words = {32'hFEEDF00D};
    send_seg(CMD_INST);
    idle(5);
    check("cnt0_next_imem0", imem[0], 32'hFEEDF00D);

    // Reset in the 3rd strobe cycle of an 8-word burst
    words.delete();
    for (int unsigned i = 0; i < 8; i++) words.push_back(32'h1000_0000 + i);
    send_seg(CMD_INST);
    seen = 0; t = 0;
    while (seen < 3 && t < 50) begin
      if (inst_load) seen++;
      if (seen < 3) begin
        @(negedge clk);
        t++;
      end
    end
    check("mid_reach_3rd", seen, 32'd3);
    rst = 1'b0;
    #1;
    check("mid_iload_drop", {31'b0, inst_load}, 32'd0);
    check("mid_prst",       {31'b0, proc_rst},  32'd1);
    check("mid_data",       data,               32'h0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    check("mid_imem0", imem[0], 32'h1000_0000);
    check("mid_imem1", imem[1], 32'h1000_0001);
    check("mid_imem2", imem[2], 32'h02FDA55A);
    words = {32'h0BADF00D};
    send_seg(CMD_INST);
    idle(5);
    check("mid_next_imem0", imem[0], 32'h0BADF00D);
    check("mid_next_imem1", imem[1], 32'h1000_0001);

    // Bad command byte in IDLE
    snap();
    send_byte(8'h77);
    idle(2);
    check("badcmd_err",     {31'b0, err},      32'd1);
    check("badcmd_strobes", (n_inst - s_inst) + (n_data - s_data), 32'd0);
    check("badcmd_ready",   {31'b0, rx_ready}, 32'd1);
    do_reset();
    check("err_cleared", {31'b0, err}, 32'd0);

    // Count one above depth
    send_byte(CMD_INST); send_byte(8'h01); send_byte(8'h01);
    idle(2);
    check("oversize_err",   {31'b0, err},      32'd1);
    check("oversize_ready", {31'b0, rx_ready}, 32'd1);
    words = {32'h12345678};
    send_seg(CMD_DATA);
    idle(5);
    check("oversize_next_dmem0", dmem[0], 32'h12345678);

`ifdef PROG_LOADER_CHECKSUM_EN
    do_reset();
    snap();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h04);
    idle(5);
    check("csum_ok_strobes", n_inst - s_inst, 32'd1);
    check("csum_ok_imem0",   imem[0],         32'h01020304);
    check("csum_ok_err",     {31'b0, err},    32'd0);
    snap();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05);
    idle(5);
    check("csum_bad_strobes", n_inst - s_inst, 32'd0);
    check("csum_bad_err",     {31'b0, err},    32'd1);
`endif

    check("never_both_strobes", n_both, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
